fp_sum_sequencer: RTL and testbench
===================================

Name: fp_sum_sequencer

Overview:
Batch controller that collects N_OPS IEEE-754 single-precision operands, such as cell-voltage or current samples, and accumulates them through one shared, externally instantiated FP32 two-input adder. It sequences N_OPS-1 adds using a req/ack handshake and owns the special-value policy. It also owns the adder timeout. It sits between the sample-acquisition stream and the pack-level statistics logic, so the adder is time-multiplexed rather than replicated.

Parameters:
N_OPS, 4, operands per batch (>=1)
DATA_W, 32, operand width (FP32 only)
TIMEOUT_CYC, 64, max cycles add_req may stay high without add_ack

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand word valid
in_ready  out  1  block accepts operand
in_data  in  32  FP32 operand
add_req  out  1  request to shared adder
add_a  out  32  adder operand A (accumulator)
add_b  out  32  adder operand B (buffered operand)
add_ack  in  1  adder result valid, single-cycle pulse
add_res  in  32  adder sum, valid when add_ack=1
out_valid  out  1  batch sum valid
out_ready  in  1  consumer accepts sum
out_sum  out  32  FP32 batch sum
out_err  out  2  bit0: special operand zeroed; bit1: adder timeout

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: in_ready=0 during the reset cycle, then 1. add_req=0, add_a=0, add_b=0, out_valid=0, out_sum=0, out_err=0. State=COLLECT, counters=0.
- FSM states: COLLECT, ADD, DONE.
- COLLECT:
  - in_ready=1.
  - Each in_valid&in_ready stores in_data into buf[wr_idx], then wr_idx++.
  - Special-value policy: if exponent==0xFF (Inf or NaN), store +0 (0x00000000) and set err[0]. Zero and denormal operands are stored unchanged.
  - On acceptance of word N_OPS-1: acc<=buf[0] (or the incoming word if N_OPS==1), rd_idx<=1, go ADD. For N_OPS==1, go DONE directly.
- ADD:
  - add_req=1, add_a=acc, add_b=buf[rd_idx]. Operands are stable while add_req=1 and not acked.
  - On add_ack: acc<=add_res, rd_idx++, tmo<=0. If rd_idx==N_OPS-1, go DONE; otherwise stay in ADD, with req held high and new operands on the next cycle.
  - Back-to-back acks give one add per cycle. Latency from the last input accept to out_valid is N_OPS-1 cycles plus adder wait cycles.
  - tmo increments on each ADD cycle without ack. When tmo reaches TIMEOUT_CYC-1 with no ack: acc<=0x7FC00000 (qNaN), set err[1], go DONE, drop add_req.
- DONE:
  - out_valid=1, out_sum=acc, out_err=err. These are held stable until out_ready.
  - On out_valid&out_ready: clear err, wr_idx, out_valid; go COLLECT.
  - in_ready=0 throughout ADD and DONE.
- add_ack received outside ADD is ignored.
- add_ack arriving on the timeout cycle wins: the result is taken and err[1] is not set.
- Reset mid-batch: the partial batch is discarded and add_req drops on the cycle after rst is sampled. No out_valid is produced for that batch.
- The block does no arithmetic itself. Rounding, overflow and sign handling belong to the shared adder.

Decomposition:
- Package bms_fp_pkg:
  - FP32 field widths (EXP_W=8, MAN_W=23), BIAS=127.
  - Constants FP_ZERO and FP_QNAN=0x7FC00000.
  - Function is_special(exp field), fsm state enum, out_err bit indices.
- Sub-module fp_operand_buf: N_OPS x 32 register file with write-side special-value zeroing and err[0] flag. The sequencer FSM instantiates it.

Test Plan:
- 4 ops 0x3F800000, 0x40000000, 0x40400000, 0x40800000 (1, 2, 3, 4); model adder acks in the request cycle -> three adds on consecutive cycles; out_sum=0x41200000, out_err=00.
- Same batch, model adder acks 5 cycles after req -> add_a/add_b stable during each wait; out_sum=0x41200000.
- Ops 1.0, 0x7F800000 (+Inf), 2.0, 3.0 -> add_b shows 0x00000000 for the Inf slot; out_sum=0x40C00000 (6.0), out_err=01.
- Adder never acks -> add_req high for exactly 64 cycles then low; out_sum=0x7FC00000, out_err=10; the next batch is accepted normally.
- out_ready low for 10 cycles in DONE -> out_sum/out_err held, in_ready=0; the batch completes on out_ready; in_ready=1 the following cycle.
- rst asserted for one cycle during ADD after 2 adds -> add_req=0 next cycle, no out_valid; a fresh 4-op batch then gives the correct sum.

Source files
------------

// File: rtl/bms_fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bms_fp_pkg
//  Purpose  : Shared FP32 field definitions, special-value constants, the
//             batch-sum sequencer state encoding and out_err bit positions.
//  Revision : 1.0  initial release
// ============================================================================
package bms_fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;
  localparam int FP_W  = 1 + EXP_W + MAN_W;

  localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;
  localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

  // out_err bit positions
  localparam int ERR_SPECIAL = 0;
  localparam int ERR_TIMEOUT = 1;
  localparam int ERR_W       = 2;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_ADD     = 2'd1,
    ST_DONE    = 2'd2
  } seq_state_e;

  // All-ones exponent encodes Inf or NaN
  function automatic logic is_special(input logic [EXP_W-1:0] exp_f);
    return exp_f == {EXP_W{1'b1}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_operand_buf.sv
`default_nettype none
// ============================================================================
//  Module   : fp_operand_buf
//  Purpose  : N_OPS x DATA_W operand register file. Inf/NaN operands are
//             replaced by +0 on write and a sticky flag records it.
//  Ports    : i_clr          clear sticky special flag
//             i_wr_en/idx/data  write port (sanitised on the way in)
//             i_rd_idx/o_rd_data  asynchronous read port
//             o_first_data   slot 0 contents
//             o_wr_clean     sanitised value of the incoming word
//             o_wr_special   incoming word is Inf/NaN
//             o_err_special  sticky flag: a special operand was zeroed
//  Revision : 1.0  initial release
// ============================================================================
module fp_operand_buf
  import bms_fp_pkg::*;
#(
  parameter int N_OPS  = 4,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [DATA_W-1:0] o_first_data,
  output logic [DATA_W-1:0] o_wr_clean,
  output logic              o_wr_special,
  output logic              o_err_special
);

  logic [DATA_W-1:0] r_mem [N_OPS];
  logic              r_err_special;

  assign o_wr_special = is_special(i_wr_data[DATA_W-2 -: EXP_W]);
  assign o_wr_clean   = o_wr_special ? FP_ZERO : i_wr_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_OPS; i++) r_mem[i] <= '0;
      r_err_special <= 1'b0;
    end else begin
      if (i_clr) r_err_special <= 1'b0;
      if (i_wr_en) begin
        r_mem[i_wr_idx] <= o_wr_clean;
        if (o_wr_special) r_err_special <= 1'b1;
      end
    end
  end

  assign o_rd_data     = r_mem[i_rd_idx];
  assign o_first_data  = r_mem[0];
  assign o_err_special = r_err_special;

endmodule
`default_nettype wire

// File: rtl/fp_sum_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fp_sum_sequencer
//  Purpose  : Collects N_OPS FP32 operands and sums them through one shared
//             external FP32 adder using a req/ack handshake, with an adder
//             timeout and Inf/NaN operand zeroing.
//  Ports    : clk, rst                      clock, sync active-high reset
//             in_valid/in_ready/in_data     operand stream
//             add_req/add_a/add_b           request to shared adder
//             add_ack/add_res               adder result (1-cycle pulse)
//             out_valid/out_ready/out_sum   batch sum stream
//             out_err  bit0 special zeroed, bit1 adder timeout
//  Revision : 1.0  initial release
// ============================================================================
module fp_sum_sequencer
  import bms_fp_pkg::*;
#(
  parameter int N_OPS       = 4,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              add_req,
  output logic [DATA_W-1:0] add_a,
  output logic [DATA_W-1:0] add_b,
  input  logic              add_ack,
  input  logic [DATA_W-1:0] add_res,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic [ERR_W-1:0]  out_err
);

  localparam int IDX_W = (N_OPS > 1) ? $clog2(N_OPS) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N_OPS - 1);
  localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(TIMEOUT_CYC - 1);

  seq_state_e        r_state;
  logic [IDX_W-1:0]  r_wr_idx;
  logic [IDX_W-1:0]  r_rd_idx;
  logic [TMO_W-1:0]  r_tmo;
  logic [DATA_W-1:0] r_acc;
  logic              r_add_req;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_sum;
  logic [ERR_W-1:0]  r_out_err;

  logic              w_accept;
  logic              w_buf_clr;
  logic [DATA_W-1:0] w_rd_data;
  logic [DATA_W-1:0] w_first;
  logic [DATA_W-1:0] w_wr_clean;
  logic              w_wr_special;
  logic              w_err_special;
  logic              w_special_seen;

  // in_ready is forced low while rst is asserted so no word is taken then
  assign in_ready       = (r_state == ST_COLLECT) && !rst;
  assign w_accept       = in_valid && in_ready;
  assign w_buf_clr      = (r_state == ST_DONE) && out_ready;
  // Includes the word being accepted this cycle (matters when N_OPS==1)
  assign w_special_seen = w_err_special || (w_accept && w_wr_special);

  fp_operand_buf #(
    .N_OPS  (N_OPS),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_buf (
    .clk           (clk),
    .rst           (rst),
    .i_clr         (w_buf_clr),
    .i_wr_en       (w_accept),
    .i_wr_idx      (r_wr_idx),
    .i_wr_data     (in_data),
    .i_rd_idx      (r_rd_idx),
    .o_rd_data     (w_rd_data),
    .o_first_data  (w_first),
    .o_wr_clean    (w_wr_clean),
    .o_wr_special  (w_wr_special),
    .o_err_special (w_err_special)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_COLLECT;
      r_wr_idx    <= '0;
      r_rd_idx    <= '0;
      r_tmo       <= '0;
      r_acc       <= FP_ZERO;
      r_add_req   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= FP_ZERO;
      r_out_err   <= '0;
    end else begin
      unique case (r_state)
        ST_COLLECT: begin
          if (w_accept) begin
            if (r_wr_idx == c_last_idx) begin
              if (N_OPS == 1) begin
                r_acc                  <= w_wr_clean;
                r_out_sum              <= w_wr_clean;
                r_out_valid            <= 1'b1;
                r_out_err[ERR_SPECIAL] <= w_special_seen;
                r_out_err[ERR_TIMEOUT] <= 1'b0;
                r_state                <= ST_DONE;
              end else begin
                r_acc     <= w_first;
                r_rd_idx  <= IDX_W'(1);
                r_tmo     <= '0;
                r_add_req <= 1'b1;
                r_state   <= ST_ADD;
              end
            end else begin
              r_wr_idx <= r_wr_idx + IDX_W'(1);
            end
          end
        end

        ST_ADD: begin
          // An ack on the timeout cycle takes priority over the timeout
          if (add_ack) begin
            r_acc <= add_res;
            r_tmo <= '0;
            if (r_rd_idx == c_last_idx) begin
              r_add_req              <= 1'b0;
              r_out_valid            <= 1'b1;
              r_out_sum              <= add_res;
              r_out_err[ERR_SPECIAL] <= w_special_seen;
              r_out_err[ERR_TIMEOUT] <= 1'b0;
              r_state                <= ST_DONE;
            end else begin
              r_rd_idx <= r_rd_idx + IDX_W'(1);
            end
          end else if (r_tmo == c_tmo_last) begin
            r_acc                  <= FP_QNAN;
            r_add_req              <= 1'b0;
            r_out_valid            <= 1'b1;
            r_out_sum              <= FP_QNAN;
            r_out_err[ERR_SPECIAL] <= w_special_seen;
            r_out_err[ERR_TIMEOUT] <= 1'b1;
            r_state                <= ST_DONE;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_err   <= '0;
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_state     <= ST_COLLECT;
          end
        end

        default: r_state <= ST_COLLECT;
      endcase
    end
  end

  // Operands are presented only while a request is outstanding
  assign add_req   = r_add_req;
  assign add_a     = r_add_req ? r_acc     : FP_ZERO;
  assign add_b     = r_add_req ? w_rd_data : FP_ZERO;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_err   = r_out_err;

endmodule
`default_nettype wire

// File: tb/tb_fp_sum_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_sum_sequencer
//  Purpose  : Directed self-checking bench for fp_sum_sequencer with a
//             table-driven model of the shared FP32 adder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fp_sum_sequencer;

  localparam logic [31:0] F1   = 32'h3F80_0000;
  localparam logic [31:0] F2   = 32'h4000_0000;
  localparam logic [31:0] F3   = 32'h4040_0000;
  localparam logic [31:0] F4   = 32'h4080_0000;
  localparam logic [31:0] F6   = 32'h40C0_0000;
  localparam logic [31:0] F10  = 32'h4120_0000;
  localparam logic [31:0] FINF = 32'h7F80_0000;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        add_req;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_ack;
  logic [31:0] add_res;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic [1:0]  out_err;

  int n_checks = 0;
  int n_err    = 0;

  // Adder model controls
  int ack_delay = 0;
  logic never_ack = 1'b0;
  int wait_cnt = 0;

  // Monitor records
  int          cyc = 0;
  int          req_cycles = 0;
  int          n_acks = 0;
  int          acc_cyc = 0;
  int          ack_cyc [64];
  logic [31:0] ack_b   [64];
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [31:0] prev_a = '0;
  logic [31:0] prev_b = '0;

  always #5 clk = ~clk;

  fp_sum_sequencer #(
    .N_OPS       (4),
    .DATA_W      (32),
    .TIMEOUT_CYC (64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .add_req   (add_req),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_ack   (add_ack),
    .add_res   (add_res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_err   (out_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Hand-computed FP32 sums for every operand pair the tests produce
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {F1,  F2}:    return F3;
      {F3,  F3}:    return F6;
      {F6,  F4}:    return F10;
      {F1,  32'h0}: return F1;
      default:      return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign add_ack = add_req && !never_ack && (wait_cnt == ack_delay);
  assign add_res = add_ack ? fadd(add_a, add_b) : 32'h0;

  always @(posedge clk) begin
    if (!add_req || add_ack) wait_cnt <= 0;
    else                     wait_cnt <= wait_cnt + 1;
  end

  always @(posedge clk) begin
    if (add_req && prev_req && !prev_ack && !rst) begin
      chk("add_a_stable", add_a, prev_a);
      chk("add_b_stable", add_b, prev_b);
    end
    if (add_req) req_cycles++;
    if (add_req && add_ack) begin
      ack_b[n_acks % 64]   = add_b;
      ack_cyc[n_acks % 64] = cyc;
      n_acks++;
    end
    if (in_valid && in_ready) acc_cyc = cyc;
    prev_req = add_req;
    prev_ack = add_ack;
    prev_a   = add_a;
    prev_b   = add_b;
    cyc++;
  end

  task automatic send_word(input logic [31:0] d);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_wait", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic send4(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d);
    send_word(a);
    send_word(b);
    send_word(c);
    send_word(d);
  endtask

  task automatic wait_out();
    int n = 0;
    while (!out_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("out_valid_wait", {31'b0, out_valid}, 32'd1);
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0;
    int n0;
    int k;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("post_rst_add_req",   {31'b0, add_req},   32'd0);
    chk("post_rst_add_a",     add_a,              32'd0);
    chk("post_rst_add_b",     add_b,              32'd0);
    chk("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("post_rst_out_sum",   out_sum,            32'd0);
    chk("post_rst_out_err",   {30'b0, out_err},   32'd0);

    // 1+2+3+4, adder acks in the request cycle
    ack_delay = 0;
    r0 = req_cycles;
    send4(F1, F2, F3, F4);
    wait_out();
    chk("t1_sum", out_sum, F10);
    chk("t1_err", {30'b0, out_err}, 32'd0);
    chk("t1_req_cycles", req_cycles - r0, 32'd3);
    chk("t1_b2b_acks", ack_cyc[(n_acks - 1) % 64] - ack_cyc[(n_acks - 3) % 64], 32'd2);
    chk("t1_latency", ack_cyc[(n_acks - 1) % 64] - acc_cyc, 32'd3);
    take_out();
    chk("t1_out_valid_clr", {31'b0, out_valid}, 32'd0);

    // Same batch, 5 wait cycles per add
    ack_delay = 5;
    r0 = req_cycles;
    send4(F1, F2, F3, F4);
    wait_out();
    chk("t2_sum", out_sum, F10);
    chk("t2_req_cycles", req_cycles - r0, 32'd18);
    take_out();

    // +Inf operand zeroed
    ack_delay = 0;
    n0 = n_acks;
    send4(F1, FINF, F2, F3);
    wait_out();
    chk("t3_inf_slot_b", ack_b[n0 % 64], 32'h0);
    chk("t3_slot2_b", ack_b[(n0 + 1) % 64], F2);
    chk("t3_sum", out_sum, F6);
    chk("t3_err", {30'b0, out_err}, 32'd1);
    take_out();

    // Adder never acks
    never_ack = 1'b1;
    r0 = req_cycles;
    send4(F1, F2, F3, F4);
    wait_out();
    chk("t4_req_cycles", req_cycles - r0, 32'd64);
    chk("t4_add_req_low", {31'b0, add_req}, 32'd0);
    chk("t4_sum", out_sum, QNAN);
    chk("t4_err", {30'b0, out_err}, 32'd2);
    take_out();
    never_ack = 1'b0;
    send4(F1, F2, F3, F4);
    wait_out();
    chk("t4_next_sum", out_sum, F10);
    chk("t4_next_err", {30'b0, out_err}, 32'd0);
    take_out();

    // Consumer back-pressure in DONE
    send4(F1, F2, F3, F4);
    wait_out();
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t5_hold_valid", {31'b0, out_valid}, 32'd1);
      chk("t5_hold_sum", out_sum, F10);
      chk("t5_hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    chk("t5_hold_err", {30'b0, out_err}, 32'd0);
    take_out();
    chk("t5_in_ready_after", {31'b0, in_ready}, 32'd1);
    chk("t5_out_valid_after", {31'b0, out_valid}, 32'd0);

    // Reset mid-ADD after two adds
    n0 = n_acks;
    send4(F1, F2, F3, F4);
    k = 0;
    while (n_acks < n0 + 2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("t6_two_adds", n_acks - n0, 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_add_req_drop", {31'b0, add_req}, 32'd0);
    for (k = 0; k < 5; k++) begin
      chk("t6_no_out_valid", {31'b0, out_valid}, 32'd0);
      @(negedge clk);
    end
    send4(F1, F2, F3, F4);
    wait_out();
    chk("t6_fresh_sum", out_sum, F10);
    chk("t6_fresh_err", {30'b0, out_err}, 32'd0);
    take_out();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
